clock_reset_seq: RTL and testbench

Consumer-side reset sequencer for the PLL output clock domain. It takes the PLL lock indication as its asynchronous active-low reset and holds the core in reset until the clock has been stable for a programmable time. It then releases two staged active-high resets: `sys_reset` for the core and `late_reset` for slow peripherals, e.g. SDRAM or video. An optional debounced user button forces a full re-sequence without losing PLL lock.

---
 rtl/clock_reset_seq.sv | 213 +++++++++++++++++++++
 tb/tb_clock_reset_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_reset_seq.sv
// -----------------------------------------------------------------------------
// clock_reset_seq
//
// Consumer-side reset sequencer for the PLL output clock domain. PLL lock is
// used as the asynchronous active-low reset. Once the release has been
// synchronized and held stable for HOLD_CYCLES, sys_reset drops; STAGE2_DELAY
// cycles later late_reset drops and ready rises. An optional debounced user
// button forces a full re-sequence without losing PLL lock.
//
// Optional feature macro: RESET_SEQ_BTN_EN
//   defined   - button synchronizer, debounce, USER state and btn_count built in
//   undefined - btn ignored, USER unreachable, btn_count tied to 0
//
// Ports:
//   clock      in   PLL output clock
//   reset_n    in   async active-low reset (PLL lock)
//   btn        in   async user reset request, active-high
//   sys_reset  out  core reset, active-high, registered
//   late_reset out  peripheral reset, active-high, registered
//   ready      out  both resets released, registered
//   btn_count  out  user resets since last lock, saturating at 255
// -----------------------------------------------------------------------------
module clock_reset_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned HOLD_CYCLES  = 1024,
    parameter int unsigned STAGE2_DELAY = 256,
    parameter int unsigned BTN_CYCLES   = 65536
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn,
    output logic       sys_reset,
    output logic       late_reset,
    output logic       ready,
    output logic [7:0] btn_count
);

    localparam int unsigned SEQ_MAX = (HOLD_CYCLES > STAGE2_DELAY) ? HOLD_CYCLES : STAGE2_DELAY;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN1,
        ST_RUN,
        ST_USER
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SEQ_W-1:0]       r_cnt;
    logic [SEQ_W-1:0]       w_next_cnt;
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic                   w_rst_sync;
    logic                   w_btn_pressed;
    logic                   r_sys_reset;
    logic                   r_late_reset;
    logic                   r_ready;
    logic                   w_sys_reset;
    logic                   w_late_reset;
    logic                   w_ready;

    // ------------------------------------------------------------------
    // Reset-release synchronizer: shifts in 1 once reset_n is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_sync = r_rst_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
`ifdef RESET_SEQ_BTN_EN
    localparam int unsigned BTN_W = $clog2(BTN_CYCLES + 1);

    logic [1:0]       r_btn_sync;
    logic             r_btn_stable;
    logic [BTN_W-1:0] r_btn_cnt;
    logic [7:0]       r_btn_count;
    logic             w_enter_user;

    // The debounce counter reaches BTN_CYCLES on the last required mismatch;
    // the flip happens on the following mismatching cycle, which gives the
    // 2 + BTN_CYCLES + 1 edge press latency seen at the outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_sync   <= '0;
            r_btn_stable <= 1'b0;
            r_btn_cnt    <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], btn};
            if (r_btn_sync[1] == r_btn_stable) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == BTN_W'(BTN_CYCLES)) begin
                r_btn_stable <= ~r_btn_stable;
                r_btn_cnt    <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + 1'b1;
            end
        end
    end

    assign w_btn_pressed = r_btn_stable;
    assign w_enter_user  = (w_next_state == ST_USER) && (r_state != ST_USER);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_count <= '0;
        end else if (w_enter_user && (r_btn_count != '1)) begin
            r_btn_count <= r_btn_count + 1'b1;
        end
    end

    assign btn_count = r_btn_count;
`else
    logic w_btn_unused;

    assign w_btn_unused  = btn;
    assign w_btn_pressed = 1'b0;
    assign btn_count     = '0;
`endif

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // HOLD acts when the counter already shows HOLD_CYCLES, RUN1 on its
    // STAGE2_DELAY-th edge; this yields release edges SYNC_STAGES+HOLD_CYCLES
    // and STAGE2_DELAY later. A press beats counter completion.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_HOLD: begin
                if (w_btn_pressed) begin
                    w_next_state = ST_USER;
                    w_next_cnt   = '0;
                end else if (r_cnt == SEQ_W'(HOLD_CYCLES)) begin
                    w_next_state = ST_RUN1;
                    w_next_cnt   = '0;
                end else if (w_rst_sync) begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_RUN1: begin
                if (w_btn_pressed) begin
                    w_next_state = ST_USER;
                    w_next_cnt   = '0;
                end else if (r_cnt == SEQ_W'(STAGE2_DELAY - 1)) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_btn_pressed) begin
                    w_next_state = ST_USER;
                    w_next_cnt   = '0;
                end
            end
            ST_USER: begin
                w_next_cnt = '0;
                if (!w_btn_pressed) begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_HOLD;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered so all three
    // change on the same edge as the state itself.
    always_comb begin
        w_sys_reset  = (w_next_state == ST_HOLD) || (w_next_state == ST_USER);
        w_late_reset = (w_next_state != ST_RUN);
        w_ready      = (w_next_state == ST_RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sys_reset  <= 1'b1;
            r_late_reset <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_sys_reset  <= w_sys_reset;
            r_late_reset <= w_late_reset;
            r_ready      <= w_ready;
        end
    end

    assign sys_reset  = r_sys_reset;
    assign late_reset = r_late_reset;
    assign ready      = r_ready;

endmodule

// File: tb/tb_clock_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_clock_reset_seq
//
// Randomized bench for clock_reset_seq. The reference model works on edge
// timestamps: the debounced button is derived from a window over the recorded
// btn samples, and reset outputs are computed from the edge at which the hold
// timer started. Covers release timing, lock loss, glitch rejection, user
// reset, saturation of btn_count, and the build without RESET_SEQ_BTN_EN.
// -----------------------------------------------------------------------------
module tb_clock_reset_seq;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned HOLD  = 16;
    localparam int unsigned S2    = 8;
    localparam int unsigned BTNC  = 4;
`ifdef RESET_SEQ_BTN_EN
    localparam bit BTN_EN = 1'b1;
`else
    localparam bit BTN_EN = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn     = 1'b0;
    logic       sys_reset;
    logic       late_reset;
    logic       ready;
    logic [7:0] btn_count;

    clock_reset_seq #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .STAGE2_DELAY(S2),
        .BTN_CYCLES  (BTNC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn       (btn),
        .sys_reset (sys_reset),
        .late_reset(late_reset),
        .ready     (ready),
        .btn_count (btn_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int k;          // edge index since lock, -1 while in reset
    bit hist[$];    // btn value sampled at each edge since lock
    bit m_stable;   // debounced button
    bit m_user;     // user reset in progress
    int m_hstart;   // edge at which the hold timer starts
    int m_cnt;      // expected btn_count
    bit e_sys, e_late, e_rdy;

    task automatic model_reset();
        k        = -1;
        hist.delete();
        m_stable = 1'b0;
        m_user   = 1'b0;
        m_hstart = SYNC - 1;
        m_cnt    = 0;
    endtask

    task automatic model_edge();
        bit prev;
        bit flip;
        bit s;
        if (!reset_n) begin
            model_reset();
        end else begin
            prev = m_stable;
            flip = 1'b1;
            k++;
            hist.push_back(btn);
            // Debounced value flips once the BTNC+1 samples seen by the
            // debounce stage all disagree with it.
            for (int j = k - 2 - int'(BTNC); j <= k - 2; j++) begin
                s = (j < 0) ? 1'b0 : hist[j];
                if (s == prev) flip = 1'b0;
            end
            if (BTN_EN && flip) m_stable = ~prev;
            if (!m_user && prev) begin
                m_user = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else if (m_user && !prev) begin
                m_user   = 1'b0;
                m_hstart = k;
            end
        end
    endtask

    task automatic model_out();
        if (k < 0 || m_user) begin
            e_sys  = 1'b1;
            e_late = 1'b1;
        end else begin
            e_sys  = (k < m_hstart + int'(HOLD) + 1);
            e_late = (k < m_hstart + int'(HOLD) + 1 + int'(S2));
        end
        e_rdy = ~e_late;
    endtask

    task automatic compare(input string pfx);
        model_out();
        chk({pfx, "sys_reset"},  32'(sys_reset),  32'(e_sys));
        chk({pfx, "late_reset"}, 32'(late_reset), 32'(e_late));
        chk({pfx, "ready"},      32'(ready),      32'(e_rdy));
        chk({pfx, "btn_count"},  32'(btn_count),  32'(m_cnt));
    endtask

    // One clock: drive on the falling edge, check 1 time unit after rising.
    task automatic step(input bit rn, input bit b);
        @(negedge clock);
        reset_n = rn;
        btn     = b;
        @(posedge clock);
        #1;
        model_edge();
        compare("");
    endtask

    // Drop lock between edges and check the asynchronous clear.
    task automatic lock_loss();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare("async_");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned len;
        bit          b;

        model_reset();

        // Reset values, then release: sys_reset edge 18, late/ready edge 26
        repeat (3) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);

        // Lock loss at edge 21 (RUN1), then re-release
        repeat (2) step(1'b0, 1'b0);
        repeat (22) step(1'b1, 1'b0);
        lock_loss();
        repeat (2) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);

        // Glitch shorter than debounce window during RUN
        repeat (3) step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        chk("glitch_ready", 32'(ready), 32'(1));

        // User reset: 20-cycle press, then full re-sequence
        repeat (20) step(1'b1, 1'b1);
        repeat (50) step(1'b1, 1'b0);

        // Long press in RUN (for the build without the button feature)
        repeat (100) step(1'b1, 1'b1);
        repeat (60) step(1'b1, 1'b0);

        // Randomized button activity with occasional lock loss
        repeat (150) begin
            len = $urandom_range(1, 40);
            b   = 1'($urandom_range(0, 1));
            repeat (len) step(1'b1, b);
            if ($urandom_range(0, 19) == 0) begin
                lock_loss();
                repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
            end
        end

        // Saturation: 300 debounced presses
        repeat (2) step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);
        repeat (300) begin
            repeat (7) step(1'b1, 1'b1);
            repeat (8) step(1'b1, 1'b0);
        end
        chk("sat_count", 32'(btn_count), BTN_EN ? 32'd255 : 32'd0);
        repeat (40) step(1'b1, 1'b0);
        chk("sat_hold", 32'(btn_count), BTN_EN ? 32'd255 : 32'd0);
        lock_loss();
        chk("sat_clear", 32'(btn_count), 32'd0);
        repeat (3) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
